// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Multi-cycle adder/subtractor. Adds CHUNK bits per clock,
//               LSB slice first, carrying between slices in a 1-bit register.
//               Result, carry-out and signed overflow load on the last slice.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int            N    = WIDTH / CHUNK;
  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Reject parameter combinations that cannot be sliced evenly.
  generate
    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("serial_adder: illegal WIDTH/CHUNK combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  logic [CHUNK:0]   c_w;
  logic [CHUNK-1:0] s_w;
  logic [WIDTH-1:0] res_next_w;
  logic             run_w;
  logic             last_w;

  assign run_w  = (state_q == RUN);
  assign last_w = (cnt_q == LAST);

  // CHUNK-bit ripple of full adders on the lowest remaining operand slice.
  always_comb begin
    c_w    = '0;
    s_w    = '0;
    c_w[0] = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      s_w[i]   = a_q[i] ^ b_q[i] ^ c_w[i];
      c_w[i+1] = (a_q[i] & b_q[i]) | (c_w[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // Partial result: slices enter at the top and move down, so after N slices
  // the full word is aligned. A single-slice configuration needs no storage.
  generate
    if (CHUNK == WIDTH) begin : g_res_direct
      assign res_next_w = s_w;
    end else begin : g_res_shift
      logic [WIDTH-CHUNK-1:0] res_q;

      // Shift finished slices down while running.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q <= '0;
        end else if (run_w) begin
          res_q <= res_next_w[WIDTH-1:CHUNK];
        end
      end

      assign res_next_w = {s_w, res_q};
    end
  endgenerate

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: capture on start from IDLE/DONE, one slice per RUN cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is A + ~B + 1; borrow-in removes that extra 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = c_w[CHUNK];
        if (last_w) begin
          sum_d   = res_next_w;
          cout_d  = c_w[CHUNK];
          // The top bit of the last slice is bit WIDTH-1 of the word.
          ovf_d   = c_w[CHUNK-1] ^ c_w[CHUNK];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits; legal range WIDTH >= 2.
REQ-002 SHALL have parameter CHUNK, default 1: bits added per clock; WIDTH % CHUNK == 0 and 1 <= CHUNK <= WIDTH, otherwise elaboration SHALL fail.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: start  input  1  request to begin an operation.
REQ-007 SHALL have port: a  input  WIDTH  operand A.
REQ-008 SHALL have port: b  input  WIDTH  operand B.
REQ-009 SHALL have port: cin  input  1  carry-in (add) / borrow-in (sub).
REQ-010 SHALL have port: sub  input  1  mode: 0 = A+B, 1 = A-B.
REQ-011 SHALL have port: busy  output  1  operation in progress.
REQ-012 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port: sum  output  WIDTH  registered result.
REQ-014 SHALL have port: cout  output  1  carry out of MSB; in sub mode 1 = no borrow.
REQ-015 SHALL have port: overflow  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; N = WIDTH/CHUNK.
REQ-017 SHALL accept start only in IDLE or DONE: capture a, b (b bitwise inverted when sub=1), sub, and initial carry = cin XOR sub; reset chunk counter to 0; enter RUN.
REQ-018 SHALL ignore start while in RUN: no recapture, no restart, no output change.
REQ-019 SHALL in RUN add one CHUNK-bit slice per clock, LSB slice first, through a CHUNK-bit ripple of full adders, propagating the carry between slices in a 1-bit register.
REQ-020 SHALL, on the edge processing slice N-1, load sum, cout and overflow and enter DONE.
REQ-021 SHALL hold sum, cout and overflow stable from that load until the next completion; they SHALL NOT change during RUN.
REQ-022 SHALL compute overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-023 SHALL drive done = 1 only in DONE, for exactly one cycle per operation.
REQ-024 SHALL drive busy = 1 only in RUN; busy and done SHALL never both be 1.
REQ-025 SHALL assert done on the Nth rising edge after the edge that accepted start; minimum start-to-start period N+1 cycles.
REQ-026 SHALL go DONE -> IDLE when start = 0, and DONE -> RUN when start = 1 (back-to-back operation).
REQ-027 SHALL handle CHUNK = WIDTH: N = 1, done on the first edge after acceptance.
REQ-028 SHALL keep all arithmetic modulo 2^WIDTH; cout is the only carry beyond bit WIDTH-1.

Reset
REQ-029 SHALL, while rst_n = 0 and independent of clk, force state IDLE, busy 0, done 0, sum 0, cout 0, overflow 0, and clear counter, carry and operand registers.
REQ-030 SHALL abort any RUN operation on reset, with no done pulse and no result update.
REQ-031 SHALL accept start on the first rising edge after rst_n deasserts.

Verification (WIDTH=8, CHUNK=1 unless stated)
REQ-032 Add wrap: a=8'hFF, b=8'h01, cin=0, sub=0 -> sum=8'h00, cout=1, overflow=0; done exactly 8 edges after start; busy high for the 8 cycles before.
REQ-033 Signed overflow: a=8'h7F, b=8'h01, sub=0 -> sum=8'h80, cout=0, overflow=1; then a=8'h05, b=8'h07, sub=1, cin=0 -> sum=8'hFE, cout=0, overflow=0.
REQ-034 Sub overflow and borrow-in: a=8'h80, b=8'h01, sub=1, cin=0 -> sum=8'h7F, cout=1, overflow=1; then a=8'h10, b=8'h01, sub=1, cin=1 -> sum=8'h0E, cout=1.
REQ-035 Protocol: start with a=8'h01, b=8'h01; pulse start with a=8'hAA at RUN cycle 3 -> result 8'h02, single done; start held in DONE -> next op starts, done 9 cycles after the first.
REQ-036 Reset mid-op: rst_n low at RUN cycle 4 -> all outputs 0 immediately, no done; a fresh add 8'h03+8'h04 after release -> sum=8'h07.
REQ-037 CHUNK=4: a=8'h9C, b=8'h64, sub=0 -> sum=8'h00, cout=1, overflow=0, done 2 edges after start; CHUNK=8: done 1 edge after start.
